// File: rtl/glift_pkg.sv
// Shared types and helpers for the GLIFT sink-side taint monitor.
package glift_pkg;

  localparam int RUN_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WARN  = 2'd1,
    ALARM = 2'd2
  } state_t;

  // Counters up to 64 bits wide; callers narrow the result.
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input logic [63:0] max
  );
    return (v >= max) ? max : v + 64'd1;
  endfunction

endpackage

// File: rtl/glift_taint_check.sv
// Flags an accepted beat whose taint reaches a sensitive sink bit.
module glift_taint_check
  import glift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             accept,
  input  logic [WIDTH-1:0] data_t,
  input  logic [WIDTH-1:0] policy_mask,
  input  logic             declassify,
  output logic             viol
);

  assign viol = accept & (|(data_t & policy_mask)) & ~declassify;

endmodule

// File: rtl/glift_taint_monitor.sv
// Trusted output boundary: registers beats, checks taint policy,
// counts violations and gates data behind a sticky alarm.
module glift_taint_monitor
  import glift_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int THRESH = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] in_data_t,
  input  logic [WIDTH-1:0] policy_mask,
  input  logic             declassify,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_data_t,
  output logic             alarm,
  input  logic             alarm_clr,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] viol_count,
  output logic [WIDTH-1:0] viol_data
);

  localparam logic [RUN_W-1:0] THR = RUN_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_n;
  logic [RUN_W-1:0] run_cnt, run_n;
  logic [WIDTH-1:0] data_q;
  logic             accept;
  logic             viol;
  logic             enter_alarm;

  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  glift_taint_check #(
    .WIDTH(WIDTH)
  ) u_check (
    .accept     (accept),
    .data_t     (in_data_t),
    .policy_mask(policy_mask),
    .declassify (declassify),
    .viol       (viol)
  );

  always_comb begin
    state_n     = state;
    run_n       = run_cnt;
    enter_alarm = 1'b0;
    if (alarm_clr) begin
      state_n = IDLE;
      run_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (viol) begin
            run_n = RUN_W'(1);
            if (THR == RUN_W'(1)) begin
              state_n     = ALARM;
              enter_alarm = 1'b1;
            end else begin
              state_n = WARN;
            end
          end
        end
        WARN: begin
          if (viol) begin
            run_n = run_cnt + RUN_W'(1);
            if (run_n == THR) begin
              state_n     = ALARM;
              enter_alarm = 1'b1;
            end
          end else if (accept) begin
            state_n = IDLE;
            run_n   = '0;
          end
        end
        ALARM: begin
          state_n = ALARM;
        end
        default: begin
          state_n = IDLE;
          run_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_cnt <= '0;
    end else begin
      state   <= state_n;
      run_cnt <= run_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      data_q     <= '0;
      out_data_t <= '0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      data_q     <= in_data;
      out_data_t <= in_data_t;
    end else if (out_ready) begin
      out_valid  <= 1'b0;
    end
  end

  // Count survives alarm_clr; only reset returns it to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      viol_count <= '0;
      viol_data  <= '0;
    end else begin
      if (viol) begin
        viol_count <= CNT_W'(sat_inc(64'(viol_count), 64'(CNT_MAX)));
      end
      if (enter_alarm) begin
        viol_data <= in_data;
      end
    end
  end

  assign alarm    = (state == ALARM);
  assign state_o  = state;
  assign out_data = alarm ? '0 : data_q;

endmodule

// File: tb/tb_glift_taint_monitor.sv
// Randomized scoreboard bench for glift_taint_monitor.
module tb_glift_taint_monitor;

  localparam int W = 8;
  localparam int TH = 4;
  localparam int CW = 16;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic [W-1:0]  in_data_t = '0;
  logic [W-1:0]  policy_mask = '0;
  logic          declassify = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;
  logic [W-1:0]  out_data_t;
  logic          alarm;
  logic          alarm_clr = 1'b0;
  logic [1:0]    state_o;
  logic [CW-1:0] viol_count;
  logic [W-1:0]  viol_data;

  glift_taint_monitor #(
    .WIDTH(W), .THRESH(TH), .CNT_W(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_data_t  (in_data_t),
    .policy_mask(policy_mask),
    .declassify (declassify),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_data_t (out_data_t),
    .alarm      (alarm),
    .alarm_clr  (alarm_clr),
    .state_o    (state_o),
    .viol_count (viol_count),
    .viol_data  (viol_data)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: occupancy, consecutive-violation run,
  // alarm flag, total count and the captured trigger data.
  bit          m_occ;
  int          m_run;
  bit          m_alarm;
  int          m_cnt;
  logic [W-1:0] m_vdata;
  logic [2*W-1:0] sb[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_occ = 0; m_run = 0; m_alarm = 0; m_cnt = 0; m_vdata = '0;
    sb.delete();
  endfunction

  function automatic int m_state();
    if (m_alarm) return 2;
    return (m_run > 0) ? 1 : 0;
  endfunction

  function automatic void model_step();
    bit acc, v;
    if (!rst_n) return;
    acc = in_valid && (!m_occ || out_ready);
    v = acc && ((in_data_t & policy_mask) != 0) && !declassify;
    if (v && m_cnt < CMAX) m_cnt++;
    if (alarm_clr) begin
      m_alarm = 0;
      m_run = 0;
    end else if (!m_alarm) begin
      if (v) begin
        m_run++;
        if (m_run >= TH) begin
          m_alarm = 1;
          m_vdata = in_data;
        end
      end else if (acc) begin
        m_run = 0;
      end
    end
    if (acc) sb.push_back({in_data, in_data_t});
    m_occ = acc || (m_occ && !out_ready);
  endfunction

  task automatic step(input logic v, input logic [W-1:0] d, t, m,
                      input logic dc, r, c);
    in_valid = v; in_data = d; in_data_t = t; policy_mask = m;
    declassify = dc; out_ready = r; alarm_clr = c;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, '0, '0, 8'hF0, 0, 1, 0);
  endtask

  // Monitor: compares the DUT against the model away from the active edge.
  always @(negedge clk) begin
    logic [2*W-1:0] e;
    chk("out_valid", 32'(out_valid), 32'(m_occ));
    chk("in_ready", 32'(in_ready), 32'(!m_occ || out_ready));
    chk("state", 32'(state_o), 32'(m_state()));
    chk("alarm", 32'(alarm), 32'(m_alarm));
    chk("viol_count", 32'(viol_count), 32'(m_cnt));
    chk("viol_data", 32'(viol_data), 32'(m_vdata));
    if (out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(out_valid), 32'(0));
      end else begin
        e = sb[0];
        chk("out_data", 32'(out_data), m_alarm ? 32'(0) : 32'(e[2*W-1:W]));
        chk("out_data_t", 32'(out_data_t), 32'(e[W-1:0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #17 rst_n = 1'b1;
    idle(2);
    // clean stream, taint misses the sensitive bits
    step(1, 8'h11, 8'h0F, 8'hF0, 0, 1, 0);
    step(1, 8'h22, 8'h0F, 8'hF0, 0, 1, 0);
    idle(2);
    // four consecutive violations reach the alarm
    step(1, 8'hA1, 8'h80, 8'hF0, 0, 1, 0);
    step(1, 8'hA2, 8'h80, 8'hF0, 0, 1, 0);
    step(1, 8'hA3, 8'h80, 8'hF0, 0, 1, 0);
    step(1, 8'hA4, 8'h80, 8'hF0, 0, 1, 0);
    step(1, 8'h55, 8'h00, 8'hF0, 0, 1, 0);
    idle(2);
    step(0, '0, '0, 8'hF0, 0, 1, 1);
    idle(1);
    // violation, clean, violation restarts the run
    step(1, 8'hA5, 8'h80, 8'hF0, 0, 1, 0);
    step(1, 8'h33, 8'h0F, 8'hF0, 0, 1, 0);
    step(1, 8'hA6, 8'h80, 8'hF0, 0, 1, 0);
    step(1, 8'h34, 8'h00, 8'hF0, 0, 1, 0);
    idle(1);
    // back-pressure: stalled beats must not be counted
    step(1, 8'hB1, 8'h00, 8'hF0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'hB2, 8'h80, 8'hF0, 0, 0, 0);
    step(1, 8'hB2, 8'h80, 8'hF0, 0, 1, 0);
    step(1, 8'hB3, 8'h00, 8'hF0, 0, 1, 0);
    idle(2);
    // clear coinciding with a violating beat, then declassify
    for (int i = 0; i < 4; i++)
      step(1, 8'hC1 + 8'(i), 8'h40, 8'hF0, 0, 1, 0);
    step(1, 8'hC5, 8'h80, 8'hF0, 0, 1, 1);
    step(1, 8'hC6, 8'h80, 8'hF0, 1, 1, 0);
    idle(2);
    // reset while a beat is held downstream
    step(1, 8'hD1, 8'h00, 8'hF0, 0, 0, 0);
    in_valid = 0; rst_n = 1'b0;
    model_reset();
    #10 rst_n = 1'b1;
    idle(2);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 7,
           W'($urandom), W'($urandom & $urandom), W'($urandom),
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 29) == 0);
    end
    idle(4);
    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/glift_taint_monitor.md
Name: glift_taint_monitor

Overview:
- Sink-side end of the GLIFT taint-tracking datapath.
- GLIFT gates produce data plus per-bit taint labels; this block consumes them at a trusted output boundary.
- It registers each beat through a valid/ready stage and checks the taint against a sensitivity policy.
- It counts violations and escalates to a sticky alarm that gates released data until software clears it.

Parameters:
WIDTH, 8, data width; taint vector has the same width
THRESH, 4, consecutive violating beats needed to enter ALARM (legal range 1..15)
CNT_W, 16, width of the saturating violation counter

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream beat valid
in_ready  output  1  block can accept a beat
in_data  input  WIDTH  upstream data
in_data_t  input  WIDTH  upstream taint label, 1 = tainted
policy_mask  input  WIDTH  1 = bit position is a sensitive sink
declassify  input  1  sampled with an accepted beat; suppresses the violation check for that beat
out_valid  output  1  registered beat valid
out_ready  input  1  downstream accepts
out_data  output  WIDTH  released data; forced to 0 while in ALARM
out_data_t  output  WIDTH  registered taint label, passed through unchanged
alarm  output  1  high in ALARM state
alarm_clr  input  1  single-cycle pulse; returns the block to IDLE
state_o  output  2  current state encoding
viol_count  output  CNT_W  total violating beats, saturating
viol_data  output  WIDTH  data of the beat that caused entry into ALARM

Behaviour:
- Reset (async, rst_n low):
  - out_valid=0, out_data=0, out_data_t=0, state=IDLE, run_cnt=0.
  - viol_count=0, viol_data=0, alarm=0.
  - in_ready reads 1 once out_valid is 0.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - accept = in_valid & in_ready.
  - On accept, the output register loads in_data/in_data_t and out_valid=1 the next cycle. Latency is 1 cycle.
  - If out_ready & out_valid and no accept, out_valid clears.
  - Simultaneous drain and accept gives full throughput, 1 beat/cycle.
- Violation:
  - viol = accept & |(in_data_t & policy_mask) & !declassify.
  - Beats that are not accepted never affect state or counters.
- viol_count:
  - Increments on every viol and saturates at all-ones.
  - Only reset clears it; alarm_clr does not.
- State encoding (state_o): IDLE=0, WARN=1, ALARM=2; 3 is unused and recovers to IDLE.
- Transitions, with run_cnt as the consecutive-violation counter:
  - IDLE:
    - viol with THRESH==1 -> ALARM.
    - viol otherwise -> WARN, run_cnt=1.
  - WARN:
    - viol: run_cnt+1; if the new value equals THRESH -> ALARM.
    - Non-violating accepted beat -> IDLE, run_cnt=0.
    - No accept: hold.
  - ALARM:
    - Sticky; further viols only bump viol_count.
    - alarm_clr -> IDLE, run_cnt=0.
- On entry into ALARM, viol_data captures in_data of the triggering beat. It holds until the next ALARM entry or reset.
- Data gating:
  - out_data = 0 whenever state==ALARM, applied combinationally to the registered value, so gating is immediate.
  - out_data_t is never gated.
- alarm_clr priority:
  - Overrides any same-cycle viol: next state IDLE, run_cnt=0.
  - viol_count still counts that beat, and viol_data is not updated.
  - alarm_clr outside ALARM forces IDLE and run_cnt=0.
- Reset mid-beat drops any held output beat (out_valid=0). Upstream must re-send.

Decomposition:
- Package glift_pkg holds:
  - the state typedef (IDLE/WARN/ALARM, 2-bit);
  - the saturating-increment function;
  - a RUN_W constant of 4 bits.
- One sub-module, glift_taint_check: combinational reduction (in_data_t & policy_mask, OR-reduce, declassify qualify) producing viol.
- The state machine, pipeline register and counters live in the top.

Test Plan:
- Reset release with in_valid=0 -> out_valid=0, in_ready=1, state_o=0, viol_count=0, alarm=0.
- Clean stream, WIDTH=8, policy_mask=8'hF0, beats 8'h11/8'h22 with taint 8'h0F, out_ready=1 -> out_data 8'h11 then 8'h22, each 1 cycle after accept; state stays IDLE; viol_count=0.
- Four consecutive beats, taint=8'h80, data 8'hA1..8'hA4, THRESH=4 -> state 1,1,1 then 2; alarm=1; viol_data=8'hA4; out_data reads 0 for beat A4 and after; viol_count=4.
- Violation, clean beat, violation -> state IDLE->WARN->IDLE->WARN; run_cnt restarts at 1; no alarm.
- out_ready held low 3 cycles with in_valid=1 -> in_ready=0; register holds its beat; no counting of stalled beats; released beat appears when out_ready=1.
- In ALARM, alarm_clr pulsed in the same cycle as a violating beat -> next state IDLE, viol_count +1, viol_data unchanged; declassify=1 with tainted beat -> no count.
